// File: rtl/seg_chase_pkg.sv
// Shared definitions for the segment chase generator: active-low segment
// patterns, the animation mode type and the loop-length constants.
package seg_chase_pkg;

   // Active-low segment patterns, bit7..0 = a,b,c,d,e,f,g,dp (dp kept off)
   localparam logic [7:0] SEG_A   = 8'b0111_1111;
   localparam logic [7:0] SEG_B   = 8'b1011_1111;
   localparam logic [7:0] SEG_C   = 8'b1101_1111;
   localparam logic [7:0] SEG_D   = 8'b1110_1111;
   localparam logic [7:0] SEG_E   = 8'b1111_0111;
   localparam logic [7:0] SEG_F   = 8'b1111_1011;
   localparam logic [7:0] SEG_G   = 8'b1111_1101;
   localparam logic [7:0] SEG_OFF = 8'b1111_1111;

   typedef enum logic {FIGURE8, PERIMETER} chase_mode_t;

   // Steps per digit in the figure-8 walk: a,b,g,e,d,c,g,f,a
   localparam int FIG8_LEN = 9;

   // Steps around the outline of an n-digit display
   function automatic int perim_len(input int n);
      return 2 * n + 4;
   endfunction

endpackage

// File: rtl/seg_chase_prescaler.sv
// Step-rate prescaler: emits a one-cycle tick every PRESCALE enabled cycles.
// Clearing en freezes the count so no partial period is lost.
module seg_chase_prescaler
   import seg_chase_pkg::*;
#(
   parameter int PRESCALE = 25_000_000
) (
   input  logic CLK,
   input  logic RST,
   input  logic en,
   output logic tick
);

   localparam int              PS_W = $clog2(PRESCALE + 1);
   localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] count_q;
   logic [PS_W-1:0] count_d;

   // Advance the count while enabled and flag the last cycle of each period
   always_comb begin
      count_d = count_q;
      tick    = 1'b0;
      if (en) begin
         if (count_q == LAST) begin
            count_d = '0;
            tick    = 1'b1;
         end else begin
            count_d = count_q + PS_W'(1);
         end
      end
   end

   // Count register, restarted by reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/seg_chase_gen.sv
// Segment chase generator: walks one lit segment across a NUM_DIGITS-digit
// common-anode display, either as a figure-8 on each digit or as a loop
// around the whole display outline.
// Optional feature macro: SEG_CHASE_LAP_DP_EN (dp marks the step after a lap).
module seg_chase_gen
   import seg_chase_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = 25_000_000
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  en,
   input  logic                  dir,
   input  logic                  mode,
   output logic [7:0]            seg,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  step_pulse,
   output logic                  wrap
);

   localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int IDX_W = 5;

   localparam logic [IDX_W-1:0] FIG8_LAST  = IDX_W'(FIG8_LEN - 1);
   localparam logic [IDX_W-1:0] PERIM_LAST = IDX_W'(perim_len(NUM_DIGITS) - 1);
   localparam logic [IDX_W-1:0] P_F        = IDX_W'(NUM_DIGITS);
   localparam logic [IDX_W-1:0] P_E        = IDX_W'(NUM_DIGITS + 1);
   localparam logic [IDX_W-1:0] P_D_END    = IDX_W'(2 * NUM_DIGITS + 1);
   localparam logic [IDX_W-1:0] P_C        = IDX_W'(2 * NUM_DIGITS + 2);
   localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
   localparam logic [DIG_W-1:0] D_BASE     = DIG_W'(2 * NUM_DIGITS + 1);
   localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

   logic                  tick;
   chase_mode_t           mode_q, mode_d;
   logic [DIG_W-1:0]      digit_q, digit_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [7:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  step_pulse_q, step_pulse_d;
   logic                  wrap_q, wrap_d;
   logic [7:0]            seg_dec;
   logic [DIG_W-1:0]      dig_sel;

   seg_chase_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .CLK  (CLK),
      .RST  (RST),
      .en   (en),
      .tick (tick)
   );

   // Next position on each tick; a mode change restarts the walk at index 0
   always_comb begin
      mode_d  = mode_q;
      digit_d = digit_q;
      idx_d   = idx_q;
      wrap_d  = 1'b0;
      if (tick) begin
         if (chase_mode_t'(mode) != mode_q) begin
            mode_d  = chase_mode_t'(mode);
            digit_d = '0;
            idx_d   = '0;
         end else if (mode_q == FIGURE8) begin
            if (!dir) begin
               if (idx_q == FIG8_LAST) begin
                  idx_d = '0;
                  if (digit_q == DIG_LAST) begin
                     digit_d = '0;
                     wrap_d  = 1'b1;
                  end else begin
                     digit_d = digit_q + DIG_W'(1);
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               if (idx_q == '0) begin
                  idx_d = FIG8_LAST;
                  if (digit_q == '0) begin
                     digit_d = DIG_LAST;
                     wrap_d  = 1'b1;
                  end else begin
                     digit_d = digit_q - DIG_W'(1);
                  end
               end else begin
                  idx_d = idx_q - IDX_W'(1);
               end
            end
         end else begin
            if (!dir) begin
               if (idx_q == PERIM_LAST) begin
                  idx_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               if (idx_q == '0) begin
                  idx_d  = PERIM_LAST;
                  wrap_d = 1'b1;
               end else begin
                  idx_d = idx_q - IDX_W'(1);
               end
            end
         end
      end
   end

   // Translate the upcoming position into a segment pattern and digit number
   always_comb begin
      seg_dec = SEG_A;
      dig_sel = '0;
      if (mode_d == FIGURE8) begin
         dig_sel = digit_d;
         case (idx_d)
            5'd1:    seg_dec = SEG_B;
            5'd2:    seg_dec = SEG_G;
            5'd3:    seg_dec = SEG_E;
            5'd4:    seg_dec = SEG_D;
            5'd5:    seg_dec = SEG_C;
            5'd6:    seg_dec = SEG_G;
            5'd7:    seg_dec = SEG_F;
            default: seg_dec = SEG_A;
         endcase
      end else if (idx_d < P_F) begin
         seg_dec = SEG_A;
         dig_sel = idx_d[DIG_W-1:0];
      end else if (idx_d == P_F) begin
         seg_dec = SEG_F;
         dig_sel = DIG_LAST;
      end else if (idx_d == P_E) begin
         seg_dec = SEG_E;
         dig_sel = DIG_LAST;
      end else if (idx_d <= P_D_END) begin
         seg_dec = SEG_D;
         dig_sel = D_BASE - idx_d[DIG_W-1:0];
      end else if (idx_d == P_C) begin
         seg_dec = SEG_C;
         dig_sel = '0;
      end else begin
         seg_dec = SEG_B;
         dig_sel = '0;
      end
   end

   // Load the display outputs on a tick and hold them between steps
   always_comb begin
      seg_d        = seg_q;
      an_d         = an_q;
      step_pulse_d = tick;
      if (tick) begin
         seg_d = seg_dec;
`ifdef SEG_CHASE_LAP_DP_EN
         seg_d[0] = ~wrap_d;
`endif
         an_d = ~(AN_ONE << dig_sel);
      end
   end

   // Position, mode and registered display state
   always_ff @(posedge CLK) begin
      if (RST) begin
         mode_q       <= chase_mode_t'(mode);
         digit_q      <= '0;
         idx_q        <= '0;
         seg_q        <= SEG_A;
         an_q         <= ~AN_ONE;
         step_pulse_q <= 1'b0;
         wrap_q       <= 1'b0;
      end else begin
         mode_q       <= mode_d;
         digit_q      <= digit_d;
         idx_q        <= idx_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         step_pulse_q <= step_pulse_d;
         wrap_q       <= wrap_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign step_pulse = step_pulse_q;
   assign wrap       = wrap_q;

endmodule

// File: tb/tb_seg_chase_gen.sv
// Self-checking bench for seg_chase_gen (4 digits, 4 cycles per step).
// A position-counter model is compared against the DUT every cycle, and
// directed scenarios pin hand-derived values at key steps.
module tb_seg_chase_gen;

   localparam int NDIG        = 4;
   localparam int PRESC       = 4;
   localparam int F8_LEN      = 9 * NDIG;
   localparam int PER_LEN     = 2 * NDIG + 4;
   localparam int STEP_BUDGET = 40;

`ifdef SEG_CHASE_LAP_DP_EN
   localparam logic [7:0] WRAP_SEG = 8'h7E;
`else
   localparam logic [7:0] WRAP_SEG = 8'h7F;
`endif

   logic            CLK;
   logic            RST;
   logic            en;
   logic            dir;
   logic            mode;
   logic [7:0]      seg;
   logic [NDIG-1:0] an;
   logic            step_pulse;
   logic            wrap;

   int checks   = 0;
   int failures = 0;

   seg_chase_gen #(
      .NUM_DIGITS (NDIG),
      .PRESCALE   (PRESC)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .en         (en),
      .dir        (dir),
      .mode       (mode),
      .seg        (seg),
      .an         (an),
      .step_pulse (step_pulse),
      .wrap       (wrap)
   );

   // Free-running clock, period 10
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Lookup tables describing the two animations
   logic [7:0] f8Seg [0:8] = '{8'h7F, 8'hBF, 8'hFD, 8'hF7, 8'hEF, 8'hDF, 8'hFD, 8'hFB, 8'h7F};
   logic [7:0] perSeg [0:PER_LEN-1];
   int         perDig [0:PER_LEN-1];

   // Build the outline walk from its geometric description
   initial begin
      for (int p = 0; p < PER_LEN; p++) begin
         if (p < NDIG) begin
            perSeg[p] = 8'h7F; perDig[p] = p;
         end else if (p == NDIG) begin
            perSeg[p] = 8'hFB; perDig[p] = NDIG - 1;
         end else if (p == NDIG + 1) begin
            perSeg[p] = 8'hF7; perDig[p] = NDIG - 1;
         end else if (p <= 2 * NDIG + 1) begin
            perSeg[p] = 8'hEF; perDig[p] = 2 * NDIG + 1 - p;
         end else if (p == 2 * NDIG + 2) begin
            perSeg[p] = 8'hDF; perDig[p] = 0;
         end else begin
            perSeg[p] = 8'hBF; perDig[p] = 0;
         end
      end
   end

   // Behavioural model: flat position counter around the active loop
   int              mEnCycles  = 0;
   int              mK         = 0;
   int              mMode      = 0;
   int              mLen       = 0;
   int              mDig       = 0;
   logic [7:0]      mSeg       = 8'h7F;
   logic [7:0]      expSeg     = 8'h7F;
   logic [NDIG-1:0] expAn      = '1;
   logic            expStep    = 1'b0;
   logic            expWrap    = 1'b0;
   bit              modelValid = 1'b0;

   always @(posedge CLK) begin
      if (RST) begin
         mEnCycles  = 0;
         mK         = 0;
         mMode      = int'(mode);
         expSeg     = 8'h7F;
         expAn      = ~NDIG'(1);
         expStep    = 1'b0;
         expWrap    = 1'b0;
         modelValid = 1'b1;
      end else begin
         expStep = 1'b0;
         expWrap = 1'b0;
         if (en) begin
            mEnCycles++;
            if (mEnCycles % PRESC == 0) begin
               expStep = 1'b1;
               if (int'(mode) != mMode) begin
                  mMode = int'(mode);
                  mK    = 0;
               end else begin
                  mLen = (mMode == 0) ? F8_LEN : PER_LEN;
                  if (!dir) begin
                     mK      = (mK + 1) % mLen;
                     expWrap = (mK == 0);
                  end else begin
                     mK      = (mK + mLen - 1) % mLen;
                     expWrap = (mK == mLen - 1);
                  end
               end
               if (mMode == 0) begin
                  mSeg = f8Seg[mK % 9];
                  mDig = mK / 9;
               end else begin
                  mSeg = perSeg[mK];
                  mDig = perDig[mK];
               end
`ifdef SEG_CHASE_LAP_DP_EN
               mSeg[0] = ~expWrap;
`endif
               expSeg = mSeg;
               expAn  = ~(NDIG'(1) << mDig);
            end
         end
      end
   end

   // Compare all outputs, reporting the actual and required values
   task automatic checkOutput(input string name, input logic [7:0] eSeg,
                              input logic [NDIG-1:0] eAn, input logic eStep,
                              input logic eWrap);
      checks++;
      if (seg !== eSeg || an !== eAn || step_pulse !== eStep || wrap !== eWrap) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got seg=%h an=%h step=%b wrap=%b, want seg=%h an=%h step=%b wrap=%b",
                  name, $time, seg, an, step_pulse, wrap, eSeg, eAn, eStep, eWrap);
      end
   endtask

   task automatic checkValue(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   // Drive all inputs just after a rising edge
   task automatic applyStimulus(input logic r, input logic e, input logic d, input logic m);
      @(posedge CLK);
      #2;
      RST  = r;
      en   = e;
      dir  = d;
      mode = m;
   endtask

   // Wait (bounded) for the next step pulse, returning the cycles waited
   task automatic waitStep(input string name, output int cycles);
      cycles = 0;
      do begin
         @(negedge CLK);
         cycles++;
      end while (step_pulse !== 1'b1 && cycles < STEP_BUDGET);
      if (step_pulse !== 1'b1) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s: no step_pulse within %0d cycles", name, STEP_BUDGET);
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge CLK) begin
      if (modelValid) begin
         checkOutput("model", expSeg, expAn, expStep, expWrap);
      end
   end

   logic [7:0]      litSeg [0:11];
   logic [NDIG-1:0] litAn  [0:11];
   int              gap;

   initial begin
      RST  = 1'b1;
      en   = 1'b1;
      dir  = 1'b0;
      mode = 1'b0;
      repeat (2) @(posedge CLK);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge CLK);
      checkOutput("reset_state", 8'h7F, 4'hE, 1'b0, 1'b0);

      // Figure-8 forward across the first digit
      litSeg = '{8'hBF, 8'hFD, 8'hF7, 8'hEF, 8'hDF, 8'hFD, 8'hFB, 8'h7F,
                 8'h00, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 8; i++) begin
         waitStep("f8_fwd", gap);
         if (i < 2) checkValue($sformatf("step_gap%0d", i + 1), gap, PRESC);
         checkOutput($sformatf("f8_step%0d", i + 1), litSeg[i], 4'hE, 1'b1, 1'b0);
      end
      waitStep("f8_fwd", gap);
      checkOutput("f8_step9_digit1", 8'h7F, 4'hD, 1'b1, 1'b0);
      for (int i = 10; i < 36; i++) waitStep("f8_fwd", gap);
      waitStep("f8_fwd", gap);
      checkOutput("f8_wrap_step36", WRAP_SEG, 4'hE, 1'b1, 1'b1);

      // Switch to perimeter and walk one full lap
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      waitStep("perim", gap);
      checkOutput("mode_to_perim", 8'h7F, 4'hE, 1'b1, 1'b0);
      litSeg = '{8'h7F, 8'h7F, 8'h7F, 8'hFB, 8'hF7, 8'hEF, 8'hEF, 8'hEF,
                 8'hEF, 8'hDF, 8'hBF, WRAP_SEG};
      litAn  = '{4'hD, 4'hB, 4'h7, 4'h7, 4'h7, 4'h7, 4'hB, 4'hD,
                 4'hE, 4'hE, 4'hE, 4'hE};
      for (int i = 0; i < 12; i++) begin
         waitStep("perim", gap);
         checkOutput($sformatf("perim_p%0d", (i + 1) % PER_LEN), litSeg[i], litAn[i],
                     1'b1, (i == 11) ? 1'b1 : 1'b0);
      end

      // Back to figure-8, go to (digit 1, idx 3), then reverse
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      waitStep("f8_again", gap);
      checkOutput("mode_to_f8", 8'h7F, 4'hE, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) waitStep("f8_again", gap);
      checkOutput("f8_at_d1_i3", 8'hF7, 4'hD, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      litSeg = '{8'hFD, 8'hBF, 8'h7F, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00};
      litAn  = '{4'hD, 4'hD, 4'hD, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0,
                 4'h0, 4'h0, 4'h0, 4'h0};
      for (int i = 0; i < 4; i++) begin
         waitStep("f8_rev", gap);
         checkOutput($sformatf("f8_rev%0d", i + 1), litSeg[i], litAn[i], 1'b1, 1'b0);
      end
      for (int i = 0; i < 8; i++) waitStep("f8_rev", gap);
      waitStep("f8_rev", gap);
      checkOutput("f8_rev_wrap", WRAP_SEG, 4'h7, 1'b1, 1'b1);

      // Pause for 10 cycles mid-period, then resume
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         checkOutput($sformatf("pause_hold%0d", i), WRAP_SEG, 4'h7, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      waitStep("resume", gap);
      checkValue("resume_gap", gap, PRESC);
      checkOutput("resume_step", 8'hFB, 4'h7, 1'b1, 1'b0);

      // Reset in the middle of a step period
      repeat (2) @(negedge CLK);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge CLK);
      checkOutput("rst_mid", 8'h7F, 4'hE, 1'b0, 1'b0);
      waitStep("after_rst", gap);
      checkValue("rst_prescaler_restart", gap, PRESC);
      for (int i = 1; i < 18; i++) waitStep("to_digit2", gap);
      checkOutput("f8_at_d2_i0", 8'h7F, 4'hB, 1'b1, 1'b0);

      // Mode change while on digit 2 restarts at the first position
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      waitStep("mode_switch", gap);
      checkOutput("mode_switch_dig2", 8'h7F, 4'hE, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) waitStep("perim_tail", gap);
      @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_chase_gen.md
Name: seg_chase_gen

Overview:
Parametrised successor to the single-rate segment chase pattern generator. It animates one lit segment across an N-digit common-anode 7-segment display at a programmable step rate. Two modes are supported: per-digit figure-8 and whole-display perimeter loop. Direction is reversible and the animation can be paused. It sits between the board clock and the seg/an pins, or feeds the display mux in larger designs.

Parameters:
NUM_DIGITS, 4, number of digits and the width of an; legal range 1..8.
PRESCALE, 25_000_000, CLK cycles per animation step; must be at least 1.
PS_W, $clog2(PRESCALE+1), prescaler counter width (derived, not overridden).

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
en  in  1  1 = animate; 0 = freeze prescaler and position, outputs hold
dir  in  1  0 = forward, 1 = reverse
mode  in  1  0 = FIGURE8, 1 = PERIMETER
seg  out  8  active-low segments; bit7..0 = a,b,c,d,e,f,g,dp
an  out  NUM_DIGITS  active-low digit enables; an[0] = digit 0
step_pulse  out  1  one-cycle pulse on every position advance
wrap  out  1  one-cycle pulse when position returns to index 0 (forward) or last index (reverse)

Behaviour:
- Reset (RST=1 at posedge): prescaler=0, digit=0, idx=0, mode_q=mode. Outputs: seg=8'b0111_1111, an=~1 (digit 0 only), step_pulse=0, wrap=0.
- Prescaler: counts 0..PRESCALE-1 while en=1; tick when count==PRESCALE-1, then count wraps to 0. en=0 holds count.
- Advance on tick: position updates. seg/an/step_pulse/wrap are registered and reflect the new position 1 cycle after the tick cycle. step_pulse and wrap last exactly one cycle.
- FIGURE8: 9 steps per digit, idx 0..8 = a,b,g,e,d,c,g,f,a.
  - Forward: (d,8)->(d+1,0); (N-1,8)->(0,0) with wrap.
  - Reverse: (d,0)->(d-1,8); (0,0)->(N-1,8) with wrap.
- PERIMETER: idx p 0..2N+3, all at one digit.
  - p<N: a on digit p.
  - p=N: f on digit N-1.
  - p=N+1: e on digit N-1.
  - N+2..2N+1: d on digit 2N+1-p.
  - 2N+2: c on digit 0.
  - 2N+3: b on digit 0.
  - Forward 2N+3->0 with wrap; reverse 0->2N+3 with wrap.
- dir change: takes effect at the next tick, reversing from the current position. No reset, no wrap.
- mode change (mode != mode_q) sampled at a tick: mode_q<=mode and position jumps to index 0 (digit 0). No wrap, step_pulse=1.
- NUM_DIGITS=1: figure-8 loops on digit 0; perimeter length 6 (a,f,e,d,c,b).
- Exactly one an bit is low and exactly one of seg[7:1] is low at all times; seg[0]=1 unless the optional feature is enabled.
- RST asserted mid-step overrides en, tick and all other inputs.

Optional Feature:
SEG_CHASE_LAP_DP_EN
- Defined: seg[0] (dp) is driven low on the same cycles wrap is high, and stays low until the next step (one full step period), on the digit then active.
- Undefined: seg[0] is tied to 1 and no extra logic is instantiated.

Decomposition:
- seg_chase_pkg holds:
  - segment constants SEG_A..SEG_G and SEG_OFF, all active-low 8-bit.
  - typedef enum logic {FIGURE8, PERIMETER} chase_mode_t.
  - FIG8_LEN = 9.
  - function perim_len(n) = 2n+4.
- Sub-module seg_chase_prescaler (PRESCALE param; CLK, RST, en -> tick). The position FSM and output decode stay in seg_chase_gen.

Test Plan:
- PRESCALE=4, N=4, mode=0, dir=0, en=1 from reset -> step_pulse every 4 cycles; seg sequence 7F,BF,FD,F7,EF,DF,FD,FB,7F on an=E, then D,B,7; wrap after the 36th step, next seg=7F on an=E.
- mode=1, dir=0, N=4 -> 12 steps: a on an=E,D,B,7; f,e on 7; d on 7,B,D,E; c,b on E; wrap on return to a/E.
- dir toggled to 1 in FIGURE8 at (digit 1, idx 3) -> next steps idx 2,1,0 on an=D, then idx 8 (7F) on an=E; no wrap; wrap asserts on (0,0)->(3,8).
- en=0 for 10 cycles mid-count -> seg/an constant, no step_pulse; resumes with the remaining prescaler count (no lost or extra steps).
- mode switched 0->1 at digit 2 -> at the next tick seg=7F, an=E, step_pulse=1, wrap=0; RST pulse mid-run -> seg=7F, an=E, prescaler restarts at 0.
- With SEG_CHASE_LAP_DP_EN, PERIMETER N=2 -> seg[0]=0 only during the step following each 8-step lap; undefined -> seg[0]=1 throughout.
